// File: rtl/mem_access_unit_if.sv
// Split-handshake data bus between the MEM stage and the data memory.
// The request side carries address, size and store payload. The response
// side returns addr_ok, data_ok and the read data.
interface mem_access_unit_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage. It holds the EX->MEM register and runs one load or store
// at a time on a variable-latency split-handshake bus. While an access is
// outstanding it stalls the pipeline. It extracts and extends load data, and
// it flags misaligned addresses and bus timeouts.
module mem_access_unit #(
    parameter int PC_W        = 32,
    parameter int RF_AW       = 5,
    parameter int STALL_W     = 6,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic [PC_W-1:0]      ex_pc,
    input  logic [7:0]           ex_mem_op,
    input  logic [31:0]          ex_addr,
    input  logic [31:0]          ex_wdata,
    input  logic                 ex_rf_we,
    input  logic [RF_AW-1:0]     ex_rf_waddr,
    input  logic [31:0]          ex_result,
    mem_access_unit_if.master    bus,
    output logic                 stallreq,
    output logic [PC_W-1:0]      wb_pc,
    output logic                 wb_rf_we,
    output logic [RF_AW-1:0]     wb_rf_waddr,
    output logic [31:0]          wb_rf_wdata,
    output logic                 fwd_load_pending,
    output logic                 excp_adel,
    output logic                 excp_ades,
    output logic [31:0]          excp_badvaddr,
    output logic                 bus_err
);

    // One-hot memory op bit positions: {lb,lbu,lh,lhu,lw,sb,sh,sw}
    localparam int OP_LB  = 7;
    localparam int OP_LBU = 6;
    localparam int OP_LH  = 5;
    localparam int OP_LHU = 4;
    localparam int OP_LW  = 3;
    localparam int OP_SB  = 2;
    localparam int OP_SH  = 1;
    localparam int OP_SW  = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
        logic half_op;
        logic word_op;
        half_op = op[OP_LH] | op[OP_LHU] | op[OP_SH];
        word_op = op[OP_LW] | op[OP_SW];
        return (half_op & a[0]) | (word_op & (a != 2'b00));
    endfunction

    function automatic logic [1:0] access_size(input logic [7:0] op);
        if (op[OP_LH] | op[OP_LHU] | op[OP_SH])
            return 2'd1;
        else if (op[OP_LW] | op[OP_SW])
            return 2'd2;
        else
            return 2'd0;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [7:0] op, input logic [1:0] a);
        if (op[OP_SB])
            return 4'b0001 << a;
        else if (op[OP_SH])
            return a[1] ? 4'b1100 : 4'b0011;
        else if (op[OP_SW])
            return 4'b1111;
        else
            return 4'b0000;
    endfunction

    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] wd);
        if (op[OP_SB])
            return {4{wd[7:0]}};
        else if (op[OP_SH])
            return {2{wd[15:0]}};
        else
            return wd;
    endfunction

    function automatic logic [31:0] load_extract(input logic [7:0] op, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        if (op[OP_LB])
            return {{24{b[7]}}, b};
        else if (op[OP_LBU])
            return {24'h0, b};
        else if (op[OP_LH])
            return {{16{h[15]}}, h};
        else if (op[OP_LHU])
            return {16'h0, h};
        else
            return w;
    endfunction

    logic [PC_W-1:0]  pc_q;
    logic [7:0]       op_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             rf_we_q;
    logic [RF_AW-1:0] rf_waddr_q;
    logic [31:0]      result_q;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;
    logic             err_q, err_d;
    logic             drop_q, drop_d;
    logic             bus_err_q, bus_err_d;

    logic is_load, is_store, is_mem, mis, mem_go;
    logic reg_upd, next_go, timeout_hit;
    logic unused_stall;

    assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};

    assign is_load  = |op_q[7:3];
    assign is_store = |op_q[2:0];
    assign is_mem   = is_load | is_store;
    assign mis      = misaligned(op_q, addr_q[1:0]);
    assign mem_go   = is_mem & ~mis;

    // The register takes new contents on flush, on a bubble, or on a capture.
    assign reg_upd     = flush | ~stall[3] | ~stall[4];
    assign next_go     = (|ex_mem_op) & ~misaligned(ex_mem_op, ex_addr[1:0]);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    // EX->MEM pipeline register: clear, bubble, capture or hold
    always_ff @(posedge clk) begin
        if (rst || flush || (stall[3] && !stall[4])) begin
            pc_q       <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            result_q   <= '0;
        end else if (!stall[3]) begin
            pc_q       <= ex_pc;
            op_q       <= ex_mem_op;
            addr_q     <= ex_addr;
            wdata_q    <= ex_wdata;
            rf_we_q    <= ex_rf_we;
            rf_waddr_q <= ex_rf_waddr;
            result_q   <= ex_result;
        end
    end

    // Bus access sequencing: request, wait for response or timeout, then present result
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        err_d     = err_q;
        drop_d    = drop_q;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && mem_go) begin
                    state_d = ST_REQ;
                    err_d   = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        if (flush) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DONE;
                            buf_d   = bus.data_rdata;
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                        drop_d  = flush;
                    end
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush)
                    drop_d = 1'b1;
                if (bus.data_data_ok) begin
                    drop_d = 1'b0;
                    if (drop_q || flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        buf_d   = bus.data_rdata;
                    end
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    buf_d     = '0;
                    err_d     = 1'b1;
                    drop_d    = 1'b0;
                    state_d   = (drop_q || flush) ? ST_IDLE : ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (reg_upd) begin
                    if (!flush && !stall[3] && next_go) begin
                        state_d = ST_REQ;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // FSM control state; reset overrides any outstanding access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Response buffer; only read in DONE, so it needs no reset
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign stallreq = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                      ((state_q == ST_IDLE) && mem_go);

    assign bus.data_req   = (state_q == ST_REQ);
    assign bus.data_wr    = is_store;
    assign bus.data_size  = access_size(op_q);
    assign bus.data_addr  = addr_q;
    assign bus.data_wstrb = store_strobe(op_q, addr_q[1:0]);
    assign bus.data_wdata = store_data(op_q, wdata_q);

    assign wb_pc       = pc_q;
    assign wb_rf_waddr = rf_waddr_q;
    assign wb_rf_we    = is_mem ? (rf_we_q & is_load & ~mis & ~err_q & (state_q == ST_DONE))
                                : rf_we_q;
    assign wb_rf_wdata = is_load ? load_extract(op_q, addr_q[1:0], buf_q) : result_q;

    assign fwd_load_pending = is_load & (state_q != ST_DONE);

    assign excp_adel     = is_load & mis;
    assign excp_ades     = is_store & mis;
    assign excp_badvaddr = mis ? addr_q : 32'h0;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. The bench plays the stall controller
// (it stops the pipeline while stallreq is high) and the data memory.
module tb_mem_access_unit;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'b1000_0000;
    localparam logic [7:0] OP_LBU = 8'b0100_0000;
    localparam logic [7:0] OP_LH  = 8'b0010_0000;
    localparam logic [7:0] OP_LHU = 8'b0001_0000;
    localparam logic [7:0] OP_LW  = 8'b0000_1000;
    localparam logic [7:0] OP_SB  = 8'b0000_0100;
    localparam logic [7:0] OP_SH  = 8'b0000_0010;
    localparam logic [7:0] OP_SW  = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] ex_pc;
    logic [7:0]  ex_mem_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_result;
    logic        stallreq;
    logic [31:0] wb_pc;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic        fwd_load_pending;
    logic        excp_adel;
    logic        excp_ades;
    logic [31:0] excp_badvaddr;
    logic        bus_err;

    logic        stall_force;
    logic [5:0]  stall_ovr;

    int n_chk  = 0;
    int n_pass = 0;

    mem_access_unit_if bus();

    mem_access_unit #(
        .PC_W(32), .RF_AW(5), .STALL_W(6), .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_pc(ex_pc), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
        .bus(bus), .stallreq(stallreq),
        .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
        .fwd_load_pending(fwd_load_pending), .excp_adel(excp_adel), .excp_ades(excp_ades),
        .excp_badvaddr(excp_badvaddr), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Stall controller: a MEM stall request freezes every stage up to MEM->WB
    assign stall = stall_force ? stall_ovr : (stallreq ? 6'b011111 : 6'b000000);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Present one instruction at EX; it is captured at the next edge
    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic we, input logic [4:0] wa, input logic [31:0] res,
                         input logic [31:0] pc);
        ex_mem_op = op; ex_addr = addr; ex_wdata = wd; ex_rf_we = we;
        ex_rf_waddr = wa; ex_result = res; ex_pc = pc;
        @(posedge clk); #1;
        ex_mem_op = OP_NOP; ex_addr = '0; ex_wdata = '0; ex_rf_we = 1'b0;
        ex_rf_waddr = '0; ex_result = '0; ex_pc = '0;
    endtask

    // Memory responder: accept at once, answer dly cycles after acceptance
    task automatic xact(input int dly, input logic [31:0] rd, output int nstall);
        int treq;
        treq = -1;
        nstall = 0;
        for (int t = 0; t < 40; t++) begin
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            if (!stallreq) return;
            nstall++;
            if (bus.data_req && treq < 0) begin
                treq = t;
                bus.data_addr_ok = 1'b1;
            end
            if (treq >= 0 && t == treq + dly) begin
                bus.data_data_ok = 1'b1;
                bus.data_rdata = rd;
            end
            @(posedge clk); #1;
        end
        chk("xact_budget", 32'(stallreq), 32'd0);
    endtask

    initial begin
        int n;
        int nw;
        int np;
        logic seen;

        rst = 1'b1; flush = 1'b0; stall_force = 1'b0; stall_ovr = '0;
        ex_pc = '0; ex_mem_op = OP_NOP; ex_addr = '0; ex_wdata = '0;
        ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_result = '0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_data_req", 32'(bus.data_req), 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_wb_we", 32'(wb_rf_we), 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        chk("rst_wb_wdata", wb_rf_wdata, 32'd0);
        chk("rst_excp", 32'({excp_adel, excp_ades, bus_err}), 32'd0);
        rst = 1'b0;

        issue(OP_LW, 32'h100, 32'h0, 1'b1, 5'd5, 32'h0, 32'h1000);
        chk("lw_fwd_pending", 32'(fwd_load_pending), 32'd1);
        chk("lw_idle_noreq", 32'(bus.data_req), 32'd0);
        xact(2, 32'h8899AABB, n);
        chk("lw_stall_cycles", 32'(n), 32'd4);
        chk("lw_wb_we", 32'(wb_rf_we), 32'd1);
        chk("lw_wb_wdata", wb_rf_wdata, 32'h8899AABB);
        chk("lw_wb_waddr", 32'(wb_rf_waddr), 32'd5);
        chk("lw_wb_pc", wb_pc, 32'h1000);
        chk("lw_fwd_done", 32'(fwd_load_pending), 32'd0);
        @(posedge clk); #1;

        issue(OP_LB, 32'h103, 32'h0, 1'b1, 5'd6, 32'h0, 32'h1004);
        xact(0, 32'h80FF0000, n);
        chk("lb_min_latency", 32'(n), 32'd2);
        chk("lb_wdata", wb_rf_wdata, 32'hFFFFFF80);
        chk("lb_we", 32'(wb_rf_we), 32'd1);

        issue(OP_LBU, 32'h103, 32'h0, 1'b1, 5'd6, 32'h0, 32'h1008);
        xact(0, 32'h80FF0000, n);
        chk("lbu_back_to_back", 32'(n), 32'd1);
        chk("lbu_wdata", wb_rf_wdata, 32'h00000080);

        issue(OP_LH, 32'h102, 32'h0, 1'b1, 5'd6, 32'h0, 32'h100C);
        xact(1, 32'h80FF0000, n);
        chk("lh_wdata", wb_rf_wdata, 32'hFFFF80FF);

        issue(OP_LHU, 32'h102, 32'h0, 1'b1, 5'd6, 32'h0, 32'h1010);
        xact(1, 32'h80FF0000, n);
        chk("lhu_wdata", wb_rf_wdata, 32'h000080FF);

        issue(OP_SB, 32'h201, 32'h000000AB, 1'b1, 5'd9, 32'h0, 32'h1014);
        chk("sb_req", 32'(bus.data_req), 32'd1);
        chk("sb_wr", 32'(bus.data_wr), 32'd1);
        chk("sb_addr", bus.data_addr, 32'h201);
        chk("sb_size", 32'(bus.data_size), 32'd0);
        chk("sb_wstrb", 32'(bus.data_wstrb), 32'b0010);
        chk("sb_wdata", bus.data_wdata, 32'hABABABAB);
        xact(0, 32'h0, n);
        chk("sb_wb_we", 32'(wb_rf_we), 32'd0);

        issue(OP_SH, 32'h202, 32'h1234CDEF, 1'b0, 5'd0, 32'h0, 32'h1018);
        chk("sh_wstrb", 32'(bus.data_wstrb), 32'b1100);
        chk("sh_wdata", bus.data_wdata, 32'hCDEFCDEF);
        chk("sh_size", 32'(bus.data_size), 32'd1);
        xact(0, 32'h0, n);

        issue(OP_LW, 32'h102, 32'h0, 1'b1, 5'd4, 32'h0, 32'h101C);
        chk("adel_flag", 32'(excp_adel), 32'd1);
        chk("adel_badvaddr", excp_badvaddr, 32'h102);
        chk("adel_noreq", 32'(bus.data_req), 32'd0);
        chk("adel_nostall", 32'(stallreq), 32'd0);
        chk("adel_wb_we", 32'(wb_rf_we), 32'd0);

        issue(OP_SW, 32'h101, 32'h5555, 1'b0, 5'd0, 32'h0, 32'h1020);
        chk("ades_flag", 32'(excp_ades), 32'd1);
        chk("ades_adel_clear", 32'(excp_adel), 32'd0);
        chk("ades_badvaddr", excp_badvaddr, 32'h101);
        @(posedge clk); #1;
        chk("ades_gone", 32'(excp_ades), 32'd0);

        issue(OP_LW, 32'h300, 32'h0, 1'b1, 5'd8, 32'h0, 32'h1024);
        seen = 1'b0; nw = 0; np = 0;
        for (int t = 0; t < 30; t++) begin
            if (bus_err) np++;
            if (seen && !stallreq) break;
            if (bus.data_req) begin
                seen = 1'b1;
                bus.data_addr_ok = 1'b1;
            end else begin
                bus.data_addr_ok = 1'b0;
                if (seen) nw++;
            end
            @(posedge clk); #1;
        end
        bus.data_addr_ok = 1'b0;
        chk("to_released", 32'(stallreq), 32'd0);
        chk("to_wait_cycles", 32'(nw), 32'd4);
        chk("to_wb_we", 32'(wb_rf_we), 32'd0);
        chk("to_wb_wdata", wb_rf_wdata, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            if (bus_err) np++;
        end
        chk("to_bus_err_pulses", 32'(np), 32'd1);
        chk("to_idle_after", 32'(stallreq), 32'd0);

        issue(OP_LW, 32'h400, 32'h0, 1'b1, 5'd7, 32'h55, 32'h1028);
        @(posedge clk); #1;
        chk("fl_req", 32'(bus.data_req), 32'd1);
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_stall_1", 32'(stallreq), 32'd1);
        chk("fl_we_1", 32'(wb_rf_we), 32'd0);
        @(posedge clk); #1;
        chk("fl_stall_2", 32'(stallreq), 32'd1);
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0;
        chk("fl_released", 32'(stallreq), 32'd0);
        chk("fl_no_write", 32'(wb_rf_we), 32'd0);
        chk("fl_wdata", wb_rf_wdata, 32'd0);

        issue(OP_LW, 32'h500, 32'h0, 1'b1, 5'd3, 32'h0, 32'h2000);
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rw_data_req", 32'(bus.data_req), 32'd0);
        chk("rw_stallreq", 32'(stallreq), 32'd0);
        chk("rw_wb_we", 32'(wb_rf_we), 32'd0);
        chk("rw_wb_pc", wb_pc, 32'd0);
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.data_data_ok = 1'b0;
        chk("spur_stallreq", 32'(stallreq), 32'd0);
        chk("spur_data_req", 32'(bus.data_req), 32'd0);
        chk("spur_wdata", wb_rf_wdata, 32'd0);

        issue(OP_NOP, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1234, 32'h40);
        chk("alu_we", 32'(wb_rf_we), 32'd1);
        chk("alu_wdata", wb_rf_wdata, 32'h1234);
        chk("alu_pc", wb_pc, 32'h40);
        ex_rf_we = 1'b1; ex_result = 32'h9999; ex_pc = 32'h44; ex_rf_waddr = 5'd2;
        stall_force = 1'b1; stall_ovr = 6'b011000;
        @(posedge clk); #1;
        chk("hold_wdata", wb_rf_wdata, 32'h1234);
        stall_ovr = 6'b001000;
        @(posedge clk); #1;
        chk("bubble_we", 32'(wb_rf_we), 32'd0);
        chk("bubble_pc", wb_pc, 32'd0);
        stall_force = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
